stream_comp_invoke: RTL and testbench

- Invoke (firing) stage paired with the stream_comp enable logic in the window-computation dataflow graph.
- On each invoke pulse it executes one mode of the stream_comp actor:
  - SETUP_COMP: consume `size` tokens from each of the data, length and command FIFOs.
  - COMP: fold the tokens into one accumulator.
  - OUTPUT: produce one result token on the output FIFO.
- Reports firing completion (FC) and the next mode back to the scheduler.

---
 rtl/stream_comp_invoke.sv | 269 ++++++++++++++++++++++++++
 tb/tb_stream_comp_invoke.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_comp_invoke.sv
//------------------------------------------------------------------------------
// stream_comp_invoke
//
// Invoke (firing) stage of the stream_comp actor. Each invoke pulse accepted in
// IDLE runs one mode:
//   00 SETUP_COMP : pop `size` tokens from the data/length/command FIFOs into
//                   local buffers and clear the accumulator.
//   01 COMP       : fold the buffered tokens into the accumulator
//                   (ADD/SUB of data*length, MAX/MIN of data).
//   10 OUTPUT     : push result(acc) to the output FIFO.
//   11 (illegal)  : no FIFO access, completes immediately.
// FC pulses for one cycle when the firing is complete; next_mode_out holds the
// mode the scheduler should run next while FC is high.
//
// Optional feature macro: STREAM_COMP_SAT_EN
//   defined     -> result saturates to the signed `width` range
//   not defined -> result is acc[width-1:0] (two's-complement wrap)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   invoke        in   one-cycle firing request (honoured only in IDLE)
//   next_mode_in  in   mode to execute, sampled with invoke
//   data_in       in   data FIFO read data, 1 cycle after rd_data
//   length_in     in   length FIFO read data (unsigned weight)
//   command_in    in   command FIFO read data (low 2 bits used)
//   rd_data       out  data FIFO pop
//   rd_length     out  length FIFO pop
//   rd_command    out  command FIFO pop
//   wr_out        out  output FIFO push
//   data_out      out  result token, valid while wr_out=1
//   next_mode_out out  next mode, valid while FC=1
//   FC            out  firing-complete pulse
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module stream_comp_invoke #(
  parameter int size  = 3,
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             invoke,
  input  logic [1:0]       next_mode_in,
  input  logic [width-1:0] data_in,
  input  logic [width-1:0] length_in,
  input  logic [width-1:0] command_in,
  output logic             rd_data,
  output logic             rd_length,
  output logic             rd_command,
  output logic             wr_out,
  output logic [width-1:0] data_out,
  output logic [1:0]       next_mode_out,
  output logic             FC
);

  // Accumulator is wide enough that size products never overflow.
  localparam int AW = 2*width + $clog2(size) + 1;
  localparam int PW = 2*width + 1;
  localparam int CW = $clog2(size+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(size-1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_READ         = 3'd1,
    S_CAPTURE_LAST = 3'd2,
    S_COMP         = 3'd3,
    S_OUTPUT       = 3'd4,
    S_DONE         = 3'd5
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic signed [AW-1:0]  r_acc;
  logic [width-1:0]      r_data_buf [size];
  logic [width-1:0]      r_len_buf  [size];
  logic [1:0]            r_cmd_buf  [size];
  logic                  r_rd;
  logic                  r_wr;
  logic [width-1:0]      r_dout;
  logic [1:0]            r_nm;
  logic                  r_fc;

  state_t                w_state_n;
  logic [CW-1:0]         w_cnt_n;
  logic signed [AW-1:0]  w_acc_n;
  logic                  w_rd_n;
  logic                  w_wr_n;
  logic [width-1:0]      w_dout_n;
  logic [1:0]            w_nm_n;
  logic                  w_fc_n;
  logic                  w_cap_en;
  logic [CW-1:0]         w_cap_idx;

  logic signed [width-1:0] w_cur_data;
  logic [width-1:0]        w_cur_len;
  logic [1:0]              w_cur_cmd;
  logic signed [PW-1:0]    w_mul_a;
  logic signed [PW-1:0]    w_mul_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [AW-1:0]    w_prod_ext;
  logic signed [AW-1:0]    w_data_ext;
  logic signed [AW-1:0]    w_fold;
  logic [width-1:0]        w_result;
  logic                    w_unused_cmd;

  // Only the opcode bits of a command token are meaningful.
  assign w_unused_cmd = ^command_in[width-1:2];

  // Token i popped in cycle i+1 arrives one cycle later, so slot = pops-1.
  assign w_cap_idx = r_cnt - ONE;

  assign w_cur_data = r_data_buf[r_cnt];
  assign w_cur_len  = r_len_buf[r_cnt];
  assign w_cur_cmd  = r_cmd_buf[r_cnt];

  // Signed data times unsigned length: zero-extend length before the signed multiply.
  assign w_mul_a    = PW'(w_cur_data);
  assign w_mul_b    = $signed({{(width+1){1'b0}}, w_cur_len});
  assign w_prod     = w_mul_a * w_mul_b;
  assign w_prod_ext = AW'(w_prod);
  assign w_data_ext = AW'(w_cur_data);

  // One fold step of the accumulator for the current element.
  always_comb begin
    w_fold = r_acc;
    case (w_cur_cmd)
      2'b00:   w_fold = r_acc + w_prod_ext;
      2'b01:   w_fold = r_acc - w_prod_ext;
      2'b10:   w_fold = (w_data_ext > r_acc) ? w_data_ext : r_acc;
      2'b11:   w_fold = (w_data_ext < r_acc) ? w_data_ext : r_acc;
      default: w_fold = r_acc;
    endcase
  end

`ifdef STREAM_COMP_SAT_EN
  localparam logic signed [width-1:0] W_MAX = {1'b0, {(width-1){1'b1}}};
  localparam logic signed [width-1:0] W_MIN = {1'b1, {(width-1){1'b0}}};

  // Clamp the wide accumulator into the signed token range.
  always_comb begin
    if (r_acc > AW'(W_MAX)) begin
      w_result = W_MAX;
    end else if (r_acc < AW'(W_MIN)) begin
      w_result = W_MIN;
    end else begin
      w_result = r_acc[width-1:0];
    end
  end
`else
  assign w_result = r_acc[width-1:0];
`endif

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_acc_n   = r_acc;
    w_rd_n    = 1'b0;
    w_wr_n    = 1'b0;
    w_dout_n  = {width{1'b0}};
    w_nm_n    = 2'b00;
    w_fc_n    = 1'b0;
    w_cap_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (invoke) begin
          w_cnt_n = {CW{1'b0}};
          case (next_mode_in)
            2'b00: begin
              w_state_n = S_READ;
              w_rd_n    = 1'b1;
              w_acc_n   = {AW{1'b0}};
            end
            2'b01: begin
              w_state_n = S_COMP;
            end
            2'b10: begin
              w_state_n = S_OUTPUT;
              w_wr_n    = 1'b1;
              w_dout_n  = w_result;
              w_fc_n    = 1'b1;
              w_nm_n    = 2'b00;
            end
            default: begin
              w_state_n = S_DONE;
              w_fc_n    = 1'b1;
              w_nm_n    = 2'b00;
            end
          endcase
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_READ: begin
        // r_cnt counts pops already issued; the first has no data yet.
        w_cap_en = (r_cnt != {CW{1'b0}});
        w_cnt_n  = r_cnt + ONE;
        if (r_cnt == LAST_IDX) begin
          w_state_n = S_CAPTURE_LAST;
        end else begin
          w_rd_n = 1'b1;
        end
      end
      S_CAPTURE_LAST: begin
        w_cap_en  = 1'b1;
        w_fc_n    = 1'b1;
        w_nm_n    = 2'b01;
        w_state_n = S_DONE;
      end
      S_COMP: begin
        w_acc_n = w_fold;
        if (r_cnt == LAST_IDX) begin
          w_fc_n    = 1'b1;
          w_nm_n    = 2'b10;
          w_state_n = S_DONE;
        end else begin
          w_cnt_n = r_cnt + ONE;
        end
      end
      S_OUTPUT: w_state_n = S_IDLE;
      S_DONE:   w_state_n = S_IDLE;
      default:  w_state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_acc   <= {AW{1'b0}};
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_dout  <= {width{1'b0}};
      r_nm    <= 2'b00;
      r_fc    <= 1'b0;
      for (int i = 0; i < size; i++) begin
        r_data_buf[i] <= {width{1'b0}};
        r_len_buf[i]  <= {width{1'b0}};
        r_cmd_buf[i]  <= 2'b00;
      end
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_acc   <= w_acc_n;
      r_rd    <= w_rd_n;
      r_wr    <= w_wr_n;
      r_dout  <= w_dout_n;
      r_nm    <= w_nm_n;
      r_fc    <= w_fc_n;
      if (w_cap_en) begin
        r_data_buf[w_cap_idx] <= data_in;
        r_len_buf[w_cap_idx]  <= length_in;
        r_cmd_buf[w_cap_idx]  <= command_in[1:0];
      end
    end
  end

  assign rd_data       = r_rd;
  assign rd_length     = r_rd;
  assign rd_command    = r_rd;
  assign wr_out        = r_wr;
  assign data_out      = r_dout;
  assign next_mode_out = r_nm;
  assign FC            = r_fc;

endmodule

// File: tb/tb_stream_comp_invoke.sv
//------------------------------------------------------------------------------
// tb_stream_comp_invoke
//
// Directed bench for stream_comp_invoke (size=3, width=16). A small FIFO
// responder inside tick() returns the next token one cycle after each pop.
// Outputs are sampled 1 time unit after the rising edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_stream_comp_invoke;

  localparam int SIZE  = 3;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             invoke;
  logic [1:0]       next_mode_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] length_in;
  logic [WIDTH-1:0] command_in;
  logic             rd_data;
  logic             rd_length;
  logic             rd_command;
  logic             wr_out;
  logic [WIDTH-1:0] data_out;
  logic [1:0]       next_mode_out;
  logic             FC;

  stream_comp_invoke #(.size(SIZE), .width(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .invoke        (invoke),
    .next_mode_in  (next_mode_in),
    .data_in       (data_in),
    .length_in     (length_in),
    .command_in    (command_in),
    .rd_data       (rd_data),
    .rd_length     (rd_length),
    .rd_command    (rd_command),
    .wr_out        (wr_out),
    .data_out      (data_out),
    .next_mode_out (next_mode_out),
    .FC            (FC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int pops    = 0;
  int q_ptr   = 0;
  logic [WIDTH-1:0] q_data [SIZE];
  logic [WIDTH-1:0] q_len  [SIZE];
  logic [WIDTH-1:0] q_cmd  [SIZE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; service any pop that was active during the cycle.
  task automatic tick();
    logic p;
    p = rd_data;
    @(posedge clk);
    #1;
    if (p) begin
      if (q_ptr < SIZE) begin
        data_in    = q_data[q_ptr];
        length_in  = q_len[q_ptr];
        command_in = q_cmd[q_ptr];
      end else begin
        data_in    = 16'hDEAD;
        length_in  = 16'hDEAD;
        command_in = 16'hDEAD;
      end
      q_ptr++;
      pops++;
    end
  endtask

  task automatic load(input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                      input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1, input logic [WIDTH-1:0] l2,
                      input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1, input logic [WIDTH-1:0] c2);
    q_data[0] = d0; q_data[1] = d1; q_data[2] = d2;
    q_len[0]  = l0; q_len[1]  = l1; q_len[2]  = l2;
    q_cmd[0]  = c0; q_cmd[1]  = c1; q_cmd[2]  = c2;
    q_ptr = 0;
    pops  = 0;
  endtask

  // One firing: check pops, pushes and FC timing cycle by cycle.
  task automatic fire(input string tag, input logic [1:0] mode, input int fc_c,
                      input logic [1:0] nm, input int rd_c, input bit wr_exp,
                      input logic [WIDTH-1:0] dout_exp);
    invoke       = 1'b1;
    next_mode_in = mode;
    tick();
    invoke       = 1'b0;
    next_mode_in = 2'b00;
    for (int c = 1; c <= fc_c; c++) begin
      chk({tag, "_rd"}, {29'd0, rd_data, rd_length, rd_command}, (c <= rd_c) ? 32'd7 : 32'd0);
      chk({tag, "_fc"}, {31'd0, FC}, (c == fc_c) ? 32'd1 : 32'd0);
      chk({tag, "_wr"}, {31'd0, wr_out}, (wr_exp && c == 1) ? 32'd1 : 32'd0);
      if (wr_exp && c == 1) chk({tag, "_dout"}, {16'd0, data_out}, {16'd0, dout_exp});
      if (c == fc_c) chk({tag, "_nm"}, {30'd0, next_mode_out}, {30'd0, nm});
      if (c < fc_c) tick();
    end
    tick();
    chk({tag, "_fc_off"}, {31'd0, FC}, 32'd0);
    chk({tag, "_wr_off"}, {31'd0, wr_out}, 32'd0);
    chk({tag, "_dout_off"}, {16'd0, data_out}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd"},   {29'd0, rd_data, rd_length, rd_command}, 32'd0);
    chk({tag, "_wr"},   {31'd0, wr_out}, 32'd0);
    chk({tag, "_dout"}, {16'd0, data_out}, 32'd0);
    chk({tag, "_nm"},   {30'd0, next_mode_out}, 32'd0);
    chk({tag, "_fc"},   {31'd0, FC}, 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    invoke       = 1'b0;
    next_mode_in = 2'b00;
    data_in      = 16'd0;
    length_in    = 16'd0;
    command_in   = 16'd0;
    load(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // 1: 5*1 + 7*2 - 2*3 = 13
    load(16'd5, 16'd7, 16'd2, 16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd1);
    fire("t1_setup", 2'b00, 5, 2'b01, 3, 1'b0, 16'd0);
    chk("t1_pops", pops, 32'd3);
    fire("t1_comp", 2'b01, 4, 2'b10, 0, 1'b0, 16'd0);
    fire("t1_out", 2'b10, 1, 2'b00, 0, 1'b1, 16'd13);

    // 2: max(0,-4)=0, min(0,9)=0, max(0,3)=3
    load(16'hFFFC, 16'd9, 16'd3, 16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd2);
    fire("t2_setup", 2'b00, 5, 2'b01, 3, 1'b0, 16'd0);
    fire("t2_comp", 2'b01, 4, 2'b10, 0, 1'b0, 16'd0);
    fire("t2_out", 2'b10, 1, 2'b00, 0, 1'b1, 16'd3);

    // 3: 3 * 30000 * 2 = 180000 -> saturates or wraps to 0xBF20
    load(16'd30000, 16'd30000, 16'd30000, 16'd2, 16'd2, 16'd2, 16'd0, 16'd0, 16'd0);
    fire("t3_setup", 2'b00, 5, 2'b01, 3, 1'b0, 16'd0);
    fire("t3_comp", 2'b01, 4, 2'b10, 0, 1'b0, 16'd0);
`ifdef STREAM_COMP_SAT_EN
    fire("t3_out", 2'b10, 1, 2'b00, 0, 1'b1, 16'h7FFF);
    fire("t3_out_again", 2'b10, 1, 2'b00, 0, 1'b1, 16'h7FFF);
`else
    fire("t3_out", 2'b10, 1, 2'b00, 0, 1'b1, 16'hBF20);
    fire("t3_out_again", 2'b10, 1, 2'b00, 0, 1'b1, 16'hBF20);
`endif

    // 4: reset during SETUP_COMP aborts the firing
    load(16'd1, 16'd2, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0);
    invoke       = 1'b1;
    next_mode_in = 2'b00;
    tick();
    invoke       = 1'b0;
    chk("t4_rd_c1", {31'd0, rd_data}, 32'd1);
    tick();
    chk("t4_rd_c2", {31'd0, rd_data}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("t4_abort");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_fc", {31'd0, FC}, 32'd0);
    end
    rst = 1'b1;
    tick();
    load(16'd1, 16'd2, 16'd3, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0);
    fire("t4_setup", 2'b00, 5, 2'b01, 3, 1'b0, 16'd0);
    chk("t4_pops", pops, 32'd3);

    // 5: invoke re-pulsed during COMP is ignored
    invoke       = 1'b1;
    next_mode_in = 2'b01;
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 2) begin
        invoke       = 1'b1;
        next_mode_in = 2'b10;
      end else begin
        invoke       = 1'b0;
        next_mode_in = 2'b00;
      end
      chk("t5_fc", {31'd0, FC}, (c == 4) ? 32'd1 : 32'd0);
      chk("t5_wr", {31'd0, wr_out}, 32'd0);
      if (c == 4) chk("t5_nm", {30'd0, next_mode_out}, 32'd2);
      tick();
    end
    invoke = 1'b0;
    fire("t5_out", 2'b10, 1, 2'b00, 0, 1'b1, 16'd6);

    // 6: illegal mode completes with no FIFO access
    load(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    fire("t6_illegal", 2'b11, 1, 2'b00, 0, 1'b0, 16'd0);
    chk("t6_pops", pops, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
